sram_62256_controller: RTL and testbench



---
 rtl/sram_62256_controller.sv | 140 ++++++++++++++
 tb/tb_sram_62256_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_62256_controller.sv
// Synchronous initiator for a single 62256 (32K x 8) asynchronous SRAM.
// Turns a valid/ready byte request stream into registered CE#/OE#/WE#,
// address and data-enable sequences. Every pin-facing signal comes straight
// from a flop, so nothing on req_* can glitch onto the SRAM pins.
module sram_62256_controller #(
    parameter int unsigned READ_WAIT_CYCLES   = 2,   // 1..15
    parameter int unsigned WRITE_PULSE_CYCLES = 2    // 1..15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic [14:0] sram_addr,
    inout  wire  [7:0]  sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    // Wait-state counter reload values. The counter counts down to zero, so a
    // state lasting N cycles is loaded with N-1.
    localparam logic [3:0] RD_LOAD = 4'(READ_WAIT_CYCLES - 1);
    localparam logic [3:0] WR_LOAD = 4'(WRITE_PULSE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [14:0] addr_q;
    logic [7:0]  wdata_q;
    logic        drive_q;
    logic        ce_n_q;
    logic        oe_n_q;
    logic        we_n_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic [7:0]  rdata_q;

    // Sequencer: state, wait counter and every registered pin/handshake output.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 15'd0;
            wdata_q      <= 8'd0;
            drive_q      <= 1'b0;
            ce_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            rdata_q      <= 8'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        // Address changes only here, while CE# is still high,
                        // so it is stable for the whole chip-enabled window.
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        ready_q <= 1'b0;
                        ce_n_q  <= 1'b0;
                        if (req_write) begin
                            state_q <= S_WR_SETUP;
                            cnt_q   <= WR_LOAD;
                            drive_q <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            cnt_q   <= RD_LOAD;
                            oe_n_q  <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q      <= sram_data;
                        resp_valid_q <= 1'b1;
                        ce_n_q       <= 1'b1;
                        oe_n_q       <= 1'b1;
                        ready_q      <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WR_SETUP: begin
                    // Data has been on the bus for a full cycle before WE# falls.
                    we_n_q  <= 1'b0;
                    state_q <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        we_n_q  <= 1'b1;
                        state_q <= S_WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    // Bus stays driven one cycle past WE# rising for data hold.
                    ce_n_q       <= 1'b1;
                    drive_q      <= 1'b0;
                    resp_valid_q <= 1'b1;
                    ready_q      <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: begin
                    ce_n_q  <= 1'b1;
                    oe_n_q  <= 1'b1;
                    we_n_q  <= 1'b1;
                    drive_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign sram_addr  = addr_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_data  = drive_q ? wdata_q : 8'bz;

endmodule

// File: tb/tb_sram_62256_controller.sv
// Bench for sram_62256_controller: two builds (2/2 and 1/15 wait states) run
// side by side, each with an SRAM model, a reference memory and a scoreboard.
module tb_sram_62256_controller;

    logic clock;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   done[2];

    typedef struct {
        bit         wr;
        logic [7:0] d;
        logic [7:0] alt;
        bit         has_alt;
        int         acc;
    } exp_t;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input bit ok, input string nm, input int cfg, input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL [cfg%0d] %s: got 0x%0h, want 0x%0h", cfg, nm, act, exp);
        end
    endtask

    task automatic fail(input string nm, input int cfg);
        n_chk++;
        n_fail++;
        $display("FAIL [cfg%0d] %s", cfg, nm);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int RW = (g == 0) ? 2 : 1;
        localparam int WP = (g == 0) ? 2 : 15;

        logic        reset, req_valid, req_ready, req_write, resp_valid;
        logic        ce_n, oe_n, we_n;
        logic [14:0] req_addr, sram_addr;
        logic [7:0]  req_wdata, resp_rdata;
        wire  [7:0]  sram_data;

        logic [7:0]  mem     [0:32767];
        logic [7:0]  ref_mem [0:32767];
        exp_t        q[$];
        int          cyc        = 0;
        int          lowcnt     = 0;
        logic [7:0]  last_rd    = 8'h00;
        logic [7:0]  cur_wd     = 8'h00;
        bit          in_abort   = 1'b0;
        bit          abort_on   = 1'b0;
        logic [14:0] abort_addr = 15'h0;
        logic [7:0]  abort_alt  = 8'h00;
        logic        prev_ce_n  = 1'b1;
        logic [14:0] prev_addr  = 15'h0;

        sram_62256_controller #(
            .READ_WAIT_CYCLES(RW),
            .WRITE_PULSE_CYCLES(WP)
        ) dut (
            .clock(clock), .reset(reset),
            .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
            .req_addr(req_addr), .req_wdata(req_wdata),
            .resp_valid(resp_valid), .resp_rdata(resp_rdata),
            .sram_addr(sram_addr), .sram_data(sram_data),
            .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n)
        );

        // SRAM model: drives on CE#&OE#, stores while CE#&WE# are low.
        assign sram_data = (!ce_n && !oe_n) ? mem[sram_addr] : 8'bz;

        initial forever @(posedge clock) cyc++;

        initial forever @(negedge clock) begin
            if (!ce_n && !we_n) mem[sram_addr] = sram_data;
        end

        // Monitor: pops the scoreboard on each response and checks pin rules.
        initial forever @(negedge clock) begin
            exp_t e;
            bit   ok;
            if (!reset && resp_valid) begin
                if (q.size() == 0) begin
                    fail("spurious resp_valid", g);
                end else begin
                    e = q.pop_front();
                    chk((cyc - e.acc) == (e.wr ? WP + 2 : RW), e.wr ? "write latency" : "read latency",
                        g, cyc - e.acc, e.wr ? WP + 2 : RW);
                    if (e.wr) begin
                        chk(resp_rdata == last_rd, "rdata held on write", g, resp_rdata, last_rd);
                    end else begin
                        ok = (resp_rdata == e.d) || (e.has_alt && resp_rdata == e.alt);
                        chk(ok, "read data", g, resp_rdata, e.d);
                        last_rd = ok ? resp_rdata : e.d;
                    end
                end
            end
            if (q.size() > 0 && (cyc - q[0].acc) > 40) begin
                fail("response timeout", g);
                void'(q.pop_front());
            end
            chk(!(oe_n == 1'b0 && we_n == 1'b0), "oe_n/we_n overlap", g, {oe_n, we_n}, 2'b11);
            if (!ce_n && !prev_ce_n)
                chk(sram_addr == prev_addr, "addr stable under ce_n", g, sram_addr, prev_addr);
            if (!ce_n)
                chk(req_ready == 1'b0, "req_ready low while busy", g, req_ready, 0);
            if (!we_n)
                chk(sram_data == cur_wd, "bus data during we_n", g, sram_data, cur_wd);
            if (!we_n) begin
                lowcnt++;
            end else begin
                if (lowcnt != 0 && !in_abort)
                    chk(lowcnt == WP, "we_n low length", g, lowcnt, WP);
                lowcnt = 0;
            end
            prev_ce_n = ce_n;
            prev_addr = sram_addr;
        end

        // Issue one request; while the DUT is busy, junk is offered with valid high.
        task automatic issue(input bit w, input logic [14:0] a, input logic [7:0] d);
            int   guard = 0;
            exp_t e;
            while (!req_ready) begin
                req_valid = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 15'($urandom);
                req_wdata = 8'($urandom);
                @(negedge clock);
                guard++;
                if (guard > 60) begin
                    fail("req_ready timeout", g);
                    return;
                end
            end
            req_valid = 1'b1;
            req_write = w;
            req_addr  = a;
            req_wdata = d;
            e.wr      = w;
            e.acc     = cyc + 1;
            e.has_alt = 1'b0;
            e.alt     = 8'h00;
            e.d       = 8'h00;
            if (w) begin
                ref_mem[a] = d;
                cur_wd     = d;
                if (abort_on && a == abort_addr) abort_on = 1'b0;
            end else begin
                e.d       = ref_mem[a];
                e.has_alt = abort_on && (a == abort_addr);
                e.alt     = abort_alt;
            end
            q.push_back(e);
            @(negedge clock);
        endtask

        task automatic wait_idle();
            int guard = 0;
            req_valid = 1'b0;
            while (q.size() != 0 && guard < 100) begin
                @(negedge clock);
                guard++;
            end
            if (q.size() != 0) fail("drain timeout", g);
            @(negedge clock);
        endtask

        initial begin
            logic [7:0]  old;
            logic [14:0] a;
            int          sel;
            int          guard;
            for (int i = 0; i < 32768; i++) begin
                mem[i]     = 8'h00;
                ref_mem[i] = 8'h00;
            end
            reset     = 1'b1;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 15'h0123;
            req_wdata = 8'h55;
            repeat (3) begin
                @(negedge clock);
                chk({ce_n, oe_n, we_n} == 3'b111, "reset strobes", g, {ce_n, oe_n, we_n}, 3'b111);
                chk(req_ready == 1'b1, "reset req_ready", g, req_ready, 1);
                chk(resp_valid == 1'b0, "reset resp_valid", g, resp_valid, 0);
                chk(resp_rdata == 8'h00, "reset resp_rdata", g, resp_rdata, 0);
                chk(sram_addr == 15'h0, "reset sram_addr", g, sram_addr, 0);
            end
            reset     = 1'b0;
            req_valid = 1'b0;
            @(negedge clock);

            // Basic write/read, then address extremes.
            issue(1'b1, 15'h0123, 8'hA5); wait_idle();
            issue(1'b0, 15'h0123, 8'h00); wait_idle();
            issue(1'b1, 15'h7FFF, 8'h3C); wait_idle();
            issue(1'b1, 15'h0000, 8'hC3); wait_idle();
            issue(1'b0, 15'h7FFF, 8'h00); wait_idle();
            issue(1'b0, 15'h0000, 8'h00); wait_idle();

            // req_valid held high, alternating write/read to one address.
            for (int i = 0; i < 8; i++)
                issue(i[0] == 1'b0, 15'h1000, 8'(8'h10 + i));
            wait_idle();

            // Reset in the middle of a write pulse.
            old = ref_mem[15'h0042];
            issue(1'b1, 15'h0042, 8'hFF);
            req_valid = 1'b0;
            guard = 0;
            while (we_n !== 1'b0 && guard < 10) begin
                @(negedge clock);
                guard++;
            end
            if (we_n !== 1'b0) fail("we_n never fell", g);
            in_abort = 1'b1;
            reset    = 1'b1;
            void'(q.pop_back());
            ref_mem[15'h0042] = old;
            abort_on   = 1'b1;
            abort_addr = 15'h0042;
            abort_alt  = 8'hFF;
            @(negedge clock);
            chk({ce_n, oe_n, we_n} == 3'b111, "abort strobes", g, {ce_n, oe_n, we_n}, 3'b111);
            chk(resp_valid == 1'b0, "abort resp_valid", g, resp_valid, 0);
            chk(resp_rdata == 8'h00, "abort resp_rdata", g, resp_rdata, 0);
            reset   = 1'b0;
            last_rd = 8'h00;
            @(negedge clock);
            in_abort = 1'b0;
            issue(1'b0, 15'h0042, 8'h00); wait_idle();

            // Random traffic over a small window plus both address extremes.
            for (int i = 0; i < 1500; i++) begin
                sel = $urandom_range(0, 9);
                a   = (sel == 0) ? 15'h0000 : (sel == 1) ? 15'h7FFF : 15'(15'h0100 + $urandom_range(0, 15));
                issue(1'($urandom_range(0, 1)), a, 8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    req_valid = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clock);
                end
            end
            wait_idle();
            done[g] = 1'b1;
        end
    end

    initial begin
        wait (done[0] && done[1]);
        repeat (3) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        fail("global watchdog", -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
